pytxseq: RTL and testbench

- Payload transmit sequencer, directly downstream of the packet-type decoder.
- Takes the decoded packet attributes (payload length in bits, payload-header presence, CRC enable, FEC 1/3 and FEC 2/3 enables, BR/EDR mode, slot count).
- Pulls raw payload bits from the payload buffer and emits the on-air payload bitstream, one bit per bit tick, to the modulator path:
  - payload header
  - body
  - CRC-16
  - FEC 2/3 zero-pad and parity, or FEC 1/3 repetition

---
 rtl/pytxseq_pkg.sv | 37 +++
 rtl/pytxseq_fec23enc.sv | 42 ++++
 rtl/pytxseq.sv | 232 +++++++++++++++++++++++
 tb/tb_pytxseq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pytxseq_pkg.sv
// Shared definitions for the payload transmit sequencer.
// Holds the sequencer state encoding, header lengths, CRC and FEC generator
// polynomials, the CRC seed layout and the bit-serial CRC update helper.
package pytxseq_pkg;

    localparam int unsigned HDR1_LEN    = 8;           // BR single-slot payload header
    localparam int unsigned HDR2_LEN    = 16;          // multi-slot / EDR payload header
    localparam int unsigned CRC_LEN     = 16;
    localparam int unsigned FEC_BLK_LEN = 10;          // info bits per (15,10) block
    localparam int unsigned FEC_PAR_LEN = 5;           // parity bits per (15,10) block

    localparam logic [15:0] CRC_POLY    = 16'h1021;    // CRC-CCITT
    localparam logic [5:0]  FEC_POLY    = 6'b110101;   // D^5+D^4+D^2+1
    localparam logic [7:0]  CRC_INIT_HI = 8'h00;       // upper byte of the CRC seed

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StBody,
        StCrc,
        StPad,
        StDone
    } state_e;

    // CRC seed: zero upper byte, UAP in the lower byte.
    function automatic logic [15:0] crc_init(input logic [7:0] uap);
        return {CRC_INIT_HI, uap};
    endfunction

    // One serial CRC-CCITT step: feedback is the register MSB xor the new bit.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/pytxseq_fec23enc.sv
// (15,10) shortened Hamming parity generator (FEC 2/3).
// A 5-bit division LFSR over FEC_POLY: info bits are shifted in, then the
// remainder is shifted out MSB first. Shifting out fills with zeros, so the
// register is naturally clear again after a full 5-bit read-out.
// Ports:
//   clk       system clock
//   rstz      synchronous active-low reset
//   clr       clear the parity register (block/packet start)
//   shift_in  absorb din as the next info bit
//   din       info bit
//   shift_out advance the parity read-out by one bit
//   dout      current parity output bit (register MSB)
module pytxseq_fec23enc
    import pytxseq_pkg::*;
(
    input  logic clk,
    input  logic rstz,
    input  logic clr,
    input  logic shift_in,
    input  logic din,
    input  logic shift_out,
    output logic dout
);

    logic [FEC_PAR_LEN-1:0] par_q;
    logic                   fb;

    assign fb   = din ^ par_q[FEC_PAR_LEN-1];
    assign dout = par_q[FEC_PAR_LEN-1];

    always_ff @(posedge clk) begin
        if (!rstz || clr) begin
            par_q <= '0;
        end else if (shift_in) begin
            par_q <= {par_q[FEC_PAR_LEN-2:0], 1'b0} ^
                     (fb ? FEC_POLY[FEC_PAR_LEN-1:0] : '0);
        end else if (shift_out) begin
            par_q <= {par_q[FEC_PAR_LEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/pytxseq.sv
// Payload transmit sequencer.
// Latches decoded packet attributes on pk_encode_start, pulls header and body
// bits from the payload buffer, appends CRC-16, and applies FEC 1/3 repetition
// or FEC 2/3 (15,10) zero-pad plus parity. One output bit per bit_tick.
// Ports:
//   clk_6M, rstz       clock, synchronous active-low reset
//   pk_encode_start    start pulse (ignored unless idle)
//   bit_tick           bit-rate strobe
//   pylenbit_f .. uap  decoded packet attributes, CRC seed byte
//   py_din/py_datareq  payload buffer bit and its consume strobe
//   py_dout/py_dvalid  encoded bit and its valid strobe (registered)
//   py_busy            sequence in progress
//   py_done_p          end-of-payload pulse
module pytxseq
    import pytxseq_pkg::*;
(
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        pk_encode_start,
    input  logic        bit_tick,
    input  logic [12:0] pylenbit_f,
    input  logic        existpyheader_f,
    input  logic        BRss_f,
    input  logic        crcencode_f,
    input  logic        fec31encode_f,
    input  logic        fec32encode_f,
    input  logic [7:0]  uap,
    input  logic        py_din,
    output logic        py_datareq,
    output logic        py_dout,
    output logic        py_dvalid,
    output logic        py_busy,
    output logic        py_done_p
);

    state_e      state_q;
    logic [4:0]  hlen_q;
    logic [12:0] blen_q;
    logic        crc_en_q;
    logic        fec31_q;
    logic        fec32_q;
    logic [15:0] crc_q;
    logic [12:0] cnt_q;      // info bits done in the current segment
    logic [1:0]  rep_q;      // FEC 1/3 repetition index
    logic [3:0]  blk_q;      // FEC 2/3 position within the 10-bit block
    logic        par_q;      // FEC 2/3 parity read-out pending
    logic [2:0]  par_cnt_q;
    logic        hold_q;     // buffer bit held for FEC 1/3 repeats

    logic [4:0]  hlen_in;
    logic        start_ok;
    logic        is_info;
    logic        from_buf;
    logic        tick_info;
    logic        tick_par;
    logic        first_rep;
    logic        last_rep;
    logic        cur_bit;
    logic [12:0] cur_len;
    logic        seg_end;
    logic        blk_wrap;
    logic        pad_need;
    state_e      next_seg;
    logic        fec_dout;

    assign hlen_in  = !existpyheader_f ? 5'd0 :
                      (BRss_f ? 5'(HDR1_LEN) : 5'(HDR2_LEN));
    assign start_ok = pk_encode_start && (state_q == StIdle);

    always_comb begin
        is_info   = (state_q == StHdr) || (state_q == StBody) ||
                    (state_q == StCrc) || (state_q == StPad);
        from_buf  = (state_q == StHdr) || (state_q == StBody);
        // Parity read-out takes priority; the segment state just waits.
        tick_par  = bit_tick && par_q;
        tick_info = bit_tick && !par_q && is_info;
        first_rep = !fec31_q || (rep_q == 2'd0);
        last_rep  = !fec31_q || (rep_q == 2'd2);
        // Combinational strobe so the buffer bit is consumed on the same tick.
        py_datareq = rstz && tick_info && from_buf && first_rep;

        cur_bit = 1'b0;
        cur_len = '0;
        unique case (state_q)
            StHdr: begin
                cur_bit = first_rep ? py_din : hold_q;
                cur_len = {8'd0, hlen_q};
            end
            StBody: begin
                cur_bit = first_rep ? py_din : hold_q;
                cur_len = blen_q;
            end
            StCrc: begin
                cur_bit = crc_q[15];
                cur_len = 13'(CRC_LEN);
            end
            default: ;
        endcase

        blk_wrap = fec32_q && (blk_q == 4'(FEC_BLK_LEN - 1));
        seg_end  = (state_q == StPad) ? (blk_q == 4'(FEC_BLK_LEN - 1))
                                      : (cnt_q == cur_len - 13'd1);
        // Evaluated on a segment's final bit: pad only if the block is still open.
        pad_need = fec32_q && !blk_wrap;

        next_seg = StDone;
        unique case (state_q)
            StHdr: begin
                if (blen_q != '0)  next_seg = StBody;
                else if (crc_en_q) next_seg = StCrc;
                else if (pad_need) next_seg = StPad;
                else               next_seg = StDone;
            end
            StBody: begin
                if (crc_en_q)      next_seg = StCrc;
                else if (pad_need) next_seg = StPad;
                else               next_seg = StDone;
            end
            StCrc:   next_seg = pad_need ? StPad : StDone;
            default: next_seg = StDone;
        endcase
    end

    pytxseq_fec23enc u_fec23enc (
        .clk       (clk_6M),
        .rstz      (rstz),
        .clr       (start_ok),
        .shift_in  (tick_info && fec32_q),
        .din       (cur_bit),
        .shift_out (tick_par),
        .dout      (fec_dout)
    );

    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            state_q   <= StIdle;
            hlen_q    <= '0;
            blen_q    <= '0;
            crc_en_q  <= 1'b0;
            fec31_q   <= 1'b0;
            fec32_q   <= 1'b0;
            crc_q     <= '0;
            cnt_q     <= '0;
            rep_q     <= '0;
            blk_q     <= '0;
            par_q     <= 1'b0;
            par_cnt_q <= '0;
            hold_q    <= 1'b0;
            py_dout   <= 1'b0;
            py_dvalid <= 1'b0;
            py_busy   <= 1'b0;
            py_done_p <= 1'b0;
        end else begin
            py_dout   <= 1'b0;
            py_dvalid <= 1'b0;
            py_done_p <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        hlen_q    <= hlen_in;
                        blen_q    <= pylenbit_f;
                        crc_en_q  <= crcencode_f;
                        fec31_q   <= fec31encode_f;
                        fec32_q   <= fec32encode_f && !fec31encode_f;
                        crc_q     <= crc_init(uap);
                        cnt_q     <= '0;
                        rep_q     <= '0;
                        blk_q     <= '0;
                        par_q     <= 1'b0;
                        par_cnt_q <= '0;
                        if ((hlen_in == '0) && (pylenbit_f == '0)) begin
                            py_done_p <= 1'b1;
                        end else begin
                            py_busy <= 1'b1;
                            state_q <= (hlen_in != '0) ? StHdr : StBody;
                        end
                    end
                end
                StDone: begin
                    if (!par_q) begin
                        state_q   <= StIdle;
                        py_busy   <= 1'b0;
                        py_done_p <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (tick_par) begin
                py_dout   <= fec_dout;
                py_dvalid <= 1'b1;
                if (par_cnt_q == 3'(FEC_PAR_LEN - 1)) begin
                    par_q     <= 1'b0;
                    par_cnt_q <= '0;
                end else begin
                    par_cnt_q <= par_cnt_q + 3'd1;
                end
            end

            if (tick_info) begin
                py_dout   <= cur_bit;
                py_dvalid <= 1'b1;
                if (from_buf && first_rep) begin
                    hold_q <= py_din;
                    crc_q  <= crc_step(crc_q, py_din);
                end
                if (fec31_q) begin
                    rep_q <= last_rep ? 2'd0 : rep_q + 2'd1;
                end
                if (last_rep) begin
                    if (state_q == StCrc) begin
                        crc_q <= {crc_q[14:0], 1'b0};
                    end
                    if (fec32_q) begin
                        blk_q <= blk_wrap ? 4'd0 : blk_q + 4'd1;
                        if (blk_wrap) begin
                            par_q <= 1'b1;
                        end
                    end
                    if (seg_end) begin
                        cnt_q   <= '0;
                        state_q <= next_seg;
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pytxseq.sv
// Self-checking bench for pytxseq: directed packet types plus randomized
// attributes, compared against a bit-list reference model of the payload.
module tb_pytxseq;

    logic        clk_6M = 1'b0;
    logic        rstz;
    logic        pk_encode_start;
    logic        bit_tick;
    logic [12:0] pylenbit_f;
    logic        existpyheader_f;
    logic        BRss_f;
    logic        crcencode_f;
    logic        fec31encode_f;
    logic        fec32encode_f;
    logic [7:0]  uap;
    logic        py_din;
    logic        py_datareq;
    logic        py_dout;
    logic        py_dvalid;
    logic        py_busy;
    logic        py_done_p;

    pytxseq u_dut (
        .clk_6M          (clk_6M),
        .rstz            (rstz),
        .pk_encode_start (pk_encode_start),
        .bit_tick        (bit_tick),
        .pylenbit_f      (pylenbit_f),
        .existpyheader_f (existpyheader_f),
        .BRss_f          (BRss_f),
        .crcencode_f     (crcencode_f),
        .fec31encode_f   (fec31encode_f),
        .fec32encode_f   (fec32encode_f),
        .uap             (uap),
        .py_din          (py_din),
        .py_datareq      (py_datareq),
        .py_dout         (py_dout),
        .py_dvalid       (py_dvalid),
        .py_busy         (py_busy),
        .py_done_p       (py_done_p)
    );

    always #5 clk_6M = ~clk_6M;

    int checks   = 0;
    int failures = 0;

    logic src [512];
    logic got_q [$];
    logic exp_q [$];
    logic [15:0] exp_crc;
    int   rd_idx, req_cnt, done_cnt, cyc, last_valid_cyc, done_cyc, start_cyc;
    logic busy_at_last, busy_at_done;
    int   tick_div;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample registered outputs, drive inputs, then see whether
    // the buffer bit on offer is consumed at the coming edge.
    task automatic step(input logic start);
        @(negedge clk_6M);
        cyc++;
        if (py_dvalid) begin
            got_q.push_back(py_dout);
            last_valid_cyc = cyc;
            busy_at_last   = py_busy;
        end
        if (py_done_p) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = py_busy;
        end
        pk_encode_start = start;
        bit_tick = (tick_div != 0) && ($urandom_range(tick_div - 1, 0) == 0);
        py_din   = src[rd_idx];
        #1;
        if (py_datareq) begin
            req_cnt++;
            if (rd_idx < 511) rd_idx++;
        end
    endtask

    // Remainder of m(D)*D^5 modulo D^5+D^4+D^2+1; m[9] is the first bit sent.
    function automatic logic [4:0] fec_rem(input logic [9:0] m);
        logic [14:0] v;
        v = {m, 5'b00000};
        for (int i = 14; i >= 5; i--) begin
            if (v[i]) v = v ^ (15'b000000000110101 << (i - 5));
        end
        return v[4:0];
    endfunction

    task automatic build_model(input int pylen, input int hlen, input bit crc,
                               input bit f31, input bit f32, input logic [7:0] u);
        logic info [$];
        logic [15:0] c;
        logic [9:0] m;
        int nsrc;
        exp_q.delete();
        nsrc = hlen + pylen;
        for (int i = 0; i < nsrc; i++) info.push_back(src[i]);
        c = {8'h00, u};
        for (int i = 0; i < nsrc; i++) begin
            logic fb;
            fb = c[15] ^ info[i];
            c  = (c << 1) ^ (fb ? 16'h1021 : 16'h0000);
        end
        exp_crc = c;
        if (nsrc == 0) return;
        if (crc) for (int k = 15; k >= 0; k--) info.push_back(c[k]);
        if (f31) begin
            foreach (info[i]) repeat (3) exp_q.push_back(info[i]);
        end else if (f32) begin
            while (info.size() % 10 != 0) info.push_back(1'b0);
            for (int b = 0; b < info.size() / 10; b++) begin
                logic [4:0] r;
                m = '0;
                for (int j = 0; j < 10; j++) begin
                    m = {m[8:0], info[b * 10 + j]};
                    exp_q.push_back(info[b * 10 + j]);
                end
                r = fec_rem(m);
                for (int k = 4; k >= 0; k--) exp_q.push_back(r[k]);
            end
        end else begin
            foreach (info[i]) exp_q.push_back(info[i]);
        end
    endtask

    task automatic run_pkt(input string tag, input int pylen, input bit hdr, input bit brss,
                           input bit crc, input bit f31, input bit f32, input logic [7:0] u,
                           input int tdiv, input int abort_at, input bit spurious);
        int hlen, n, nmis, nchk;
        bit aborted, spur_done;
        logic [15:0] tail;
        hlen = hdr ? (brss ? 8 : 16) : 0;
        for (int i = 0; i < 512; i++) src[i] = 1'($urandom_range(1, 0));
        build_model(pylen, hlen, crc, f31, f32, u);
        got_q.delete();
        rd_idx = 0; req_cnt = 0; done_cnt = 0;
        last_valid_cyc = -1; done_cyc = -1;
        busy_at_last = 1'b0; busy_at_done = 1'b1;
        pylenbit_f = 13'(pylen); existpyheader_f = hdr; BRss_f = brss;
        crcencode_f = crc; fec31encode_f = f31; fec32encode_f = f32;
        // Idle ticks with a different seed byte on the bus must do nothing.
        uap = ~u; tick_div = 1;
        repeat (4) step(1'b0);
        uap = u; tick_div = tdiv;
        step(1'b1);
        start_cyc = cyc;
        n = 0; aborted = 0; spur_done = 0;
        while (done_cnt == 0 && n < 20000 && !aborted) begin
            step(1'b0);
            n++;
            if (spurious && !spur_done && got_q.size() >= 7) begin
                uap = ~u; pylenbit_f = 13'(pylen + 5); crcencode_f = ~crc;
                step(1'b1);
                uap = u; pylenbit_f = 13'(pylen); crcencode_f = crc;
                spur_done = 1;
            end
            if (abort_at > 0 && got_q.size() == abort_at) begin
                rstz = 1'b0;
                @(negedge clk_6M);
                check_eq({tag, ".abort_outs"},
                         {27'd0, py_busy, py_dvalid, py_dout, py_done_p, py_datareq}, 32'd0);
                rstz = 1'b1;
                aborted = 1;
            end
        end
        repeat (20) step(1'b0);
        nmis = 0;
        nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nchk; i++) if (got_q[i] !== exp_q[i]) nmis++;
        check_eq({tag, ".bit_mismatches"}, nmis, 0);
        if (abort_at > 0) begin
            check_eq({tag, ".nvalid"}, got_q.size(), abort_at);
            check_eq({tag, ".ndone"}, done_cnt, 0);
            return;
        end
        check_eq({tag, ".nvalid"}, got_q.size(), exp_q.size());
        check_eq({tag, ".nreq"}, req_cnt, hlen + pylen);
        check_eq({tag, ".ndone"}, done_cnt, 1);
        check_eq({tag, ".busy_at_done"}, busy_at_done, 0);
        if (exp_q.size() > 0) begin
            check_eq({tag, ".done_latency"}, done_cyc - last_valid_cyc, 1);
            check_eq({tag, ".busy_at_last"}, busy_at_last, 1);
        end else begin
            check_eq({tag, ".null_done_latency"}, done_cyc - start_cyc, 1);
        end
        if (crc && !f31 && !f32 && got_q.size() >= 16) begin
            for (int k = 0; k < 16; k++) tail[15 - k] = got_q[got_q.size() - 16 + k];
            check_eq({tag, ".crc_tail"}, tail, exp_crc);
        end
    endtask

    initial begin
        rstz = 1'b0; pk_encode_start = 1'b0; bit_tick = 1'b0;
        pylenbit_f = '0; existpyheader_f = 1'b0; BRss_f = 1'b0; crcencode_f = 1'b0;
        fec31encode_f = 1'b0; fec32encode_f = 1'b0; uap = '0; py_din = 1'b0;
        cyc = 0; tick_div = 0;
        for (int i = 0; i < 512; i++) src[i] = 1'b0;
        repeat (3) step(1'b0);
        check_eq("reset.busy", py_busy, 0);
        check_eq("reset.dvalid", py_dvalid, 0);
        check_eq("reset.done", py_done_p, 0);
        check_eq("reset.dout", py_dout, 0);
        check_eq("reset.datareq", py_datareq, 0);
        rstz = 1'b1;
        repeat (2) step(1'b0);

        run_pkt("dh1",   216, 1, 1, 1, 0, 0, 8'h47, 2, 0, 1);
        run_pkt("dm1",    64, 1, 1, 1, 0, 1, 8'h47, 2, 0, 0);
        run_pkt("hv1",    80, 0, 0, 0, 1, 0, 8'h47, 1, 0, 0);
        run_pkt("null",    0, 0, 0, 1, 0, 0, 8'h47, 1, 0, 0);
        run_pkt("dh3hdr", 100, 1, 0, 1, 0, 0, 8'h5a, 2, 0, 1);
        run_pkt("hdronly", 0, 1, 1, 1, 0, 1, 8'h11, 1, 0, 0);
        run_pkt("abort", 216, 1, 1, 1, 0, 0, 8'h47, 2, 50, 0);
        run_pkt("post_abort", 216, 1, 1, 1, 0, 0, 8'h47, 1, 0, 0);
        run_pkt("both_fec", 30, 1, 0, 1, 1, 1, 8'hc3, 1, 0, 0);

        for (int r = 0; r < 10; r++) begin
            int  pl;
            bit  f31, f32;
            pl  = (r == 3) ? 0 : int'($urandom_range(120, 0));
            f31 = ($urandom_range(3, 0) == 0);
            f32 = ($urandom_range(1, 0) == 1);
            run_pkt($sformatf("rand%0d", r), pl, 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), f31, f32,
                    8'($urandom), int'($urandom_range(3, 1)), 0, 1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
